fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Core-side initiator for the shared FPU datapath.
- Accepts one decoded FP instruction at a time from the execute stage and registers its opcode and operands.
- Holds them stable on the FPU inputs for the op's fixed latency, then captures the FPU result and issues a one-cycle writeback to the FP or integer register file.
- Sits between decode/execute and the fpu instance; the fpu's selection and operand inputs are driven only by this block.

Parameters:
- LAT_ADDSUB, 2, cycles from stable FPU inputs to valid result for funct7 0x00/0x04.
- LAT_CVT, 1, cycles for funct7 0x68 (fcvt.s.w).
- CNT_W, 2, width of latency counter; must hold max(LAT_ADDSUB, LAT_CVT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents an FP op.
- req_ready  out  1  op accepted this cycle when req_valid && req_ready.
- req_funct3  in  3  instruction funct3.
- req_funct7  in  7  instruction funct7.
- req_rd  in  5  destination register index.
- req_x1, req_x2  in  32 each  source operands.
- flush  in  1  abort the in-flight op; discard its result.
- fpu_funct3  out  3  registered, to FPU.
- fpu_funct7  out  7  registered, to FPU.
- fpu_x1, fpu_x2  out  32 each  registered, to FPU.
- fpu_y  in  32  FPU result.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  writeback destination.
- wb_data  out  32  writeback value.
- wb_is_int  out  1  result targets the integer regfile (funct7 0x50 or 0x70).
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; all fpu_* outputs, wb_* outputs, counter and busy = 0. Reset mid-op abandons the op silently; no wb_valid.
- Latency decode L(funct7): 0x00 or 0x04 -> LAT_ADDSUB; 0x68 -> LAT_CVT; all other values, including unknown, -> 0.
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE || state==DONE) && !flush.
- Accept in cycle t:
  - Register funct3, funct7, rd, x1, x2 and wb_is_int.
  - Load counter with L.
  - Go to EXEC. FPU inputs are stable from t+1.
- EXEC:
  - If counter != 0: decrement.
  - If counter == 0: capture fpu_y into wb_data, set wb_valid=1, go to DONE.
  - Capture cycle is t+1+L; wb_valid is high in cycle t+2+L.
- DONE:
  - wb_valid high for exactly this cycle.
  - On an accept, go to EXEC with the new op (back-to-back, one issue per L+2 cycles).
  - Otherwise go to IDLE.
- wb_valid is a pulse with no backpressure. wb_rd, wb_data and wb_is_int hold their last values until the next capture.
- fpu_* outputs change only on accept, so operands stay stable through the whole EXEC window. This is required: the add/sub pipeline samples them over LAT_ADDSUB cycles.
- Flush:
  - In EXEC: next state IDLE; no capture; wb_valid stays 0.
  - In DONE: the current wb_valid pulse is not suppressed, because it was already registered. No new accept that cycle.
  - Flush and req_valid in the same cycle: flush wins; the request is not accepted and must be re-presented.
  - Flush in IDLE: no effect.
- Counter never wraps; it only loads on accept and decrements in EXEC while nonzero.
- No X on outputs after reset; unknown funct7 follows the L=0 path.

Decomposition:
- Shared package fpu_pkg holds:
  - funct7 constants: FADD=0x00, FSUB=0x04, FMUL=0x08, FSGNJ=0x10, FCMP=0x50, FCVT_S_W=0x68, FMV_X_W=0x70, FMV_W_X=0x78.
  - State encoding.
  - Function is_int_dest(funct7).
- One natural sub-module: fpu_lat_dec, combinational funct7 -> L and wb_is_int. The same decode is reused by the hazard unit.

Test Plan:
- fadd, funct7=0x00, x1=0x3F800000, x2=0x40000000, accept at t -> wb_valid only at t+4; wb_data=0x40400000; wb_is_int=0; fpu_x1/x2 stable over t+1..t+3.
- fle.s, funct7=0x50, funct3=0, x1=0x3F800000, x2=0x40000000, rd=7, accept at t -> wb_valid at t+2; wb_data=1; wb_rd=7; wb_is_int=1.
- fcvt.s.w, funct7=0x68, x1=5, accept at t -> wb_valid at t+3; wb_data=0x40A00000.
- Back-to-back: fmul 2.0*3.0 then fsub 1.0-1.0 held valid -> second op accepted in the DONE cycle of the first. wb_data=0x40C00000 at t+2, then 0x00000000 at t+6; exactly two pulses.
- fadd accepted at t, flush at t+2 -> no wb_valid through t+10; req_ready high at t+3.
- Same-cycle req_valid+flush in IDLE -> req_ready=0, no accept. Assert rst at t+2 of an fadd -> all outputs 0 immediately; no wb_valid after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: funct7 opcodes, controller states, dest decode.
package fpu_pkg;

    localparam logic [6:0] FADD     = 7'h00;
    localparam logic [6:0] FSUB     = 7'h04;
    localparam logic [6:0] FMUL     = 7'h08;
    localparam logic [6:0] FSGNJ    = 7'h10;
    localparam logic [6:0] FCMP     = 7'h50;
    localparam logic [6:0] FCVT_S_W = 7'h68;
    localparam logic [6:0] FMV_X_W  = 7'h70;
    localparam logic [6:0] FMV_W_X  = 7'h78;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_int_dest(input logic [6:0] funct7);
        return (funct7 == FCMP) || (funct7 == FMV_X_W);
    endfunction

endpackage

// File: rtl/fpu_lat_dec.sv
// funct7 -> fixed FPU latency and integer-destination flag.
module fpu_lat_dec
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_CVT    = 1,
    parameter int CNT_W      = 2
) (
    input  logic [6:0]       funct7,
    output logic [CNT_W-1:0] lat,
    output logic             is_int
);

    // Anything not listed, including unknown encodings, takes the L=0 path.
    always_comb begin
        lat = '0;
        unique case (1'b1)
            (funct7 == FADD),
            (funct7 == FSUB):     lat = CNT_W'(LAT_ADDSUB);
            (funct7 == FCVT_S_W): lat = CNT_W'(LAT_CVT);
            default:              lat = '0;
        endcase
    end

    assign is_int = is_int_dest(funct7);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Core-side issue controller for the shared FPU: holds operands for the op
// latency, captures the result and pulses a one-cycle writeback.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_CVT    = 1,
    parameter int CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic        flush,
    output logic [2:0]  fpu_funct3,
    output logic [6:0]  fpu_funct7,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_is_int,
    output logic        busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] dec_lat;
    logic             dec_int;
    logic [4:0]       rd_q;
    logic             int_q;
    logic             accept;
    logic             capture;

    fpu_lat_dec #(
        .LAT_ADDSUB(LAT_ADDSUB),
        .LAT_CVT   (LAT_CVT),
        .CNT_W     (CNT_W)
    ) u_lat_dec (
        .funct7(req_funct7),
        .lat   (dec_lat),
        .is_int(dec_int)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                req_ready = !flush;
                accept    = req_valid && !flush;
                state_d   = accept ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // FPU inputs move only on accept so the add/sub pipe sees stable operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_funct3 <= '0;
            fpu_funct7 <= '0;
            fpu_x1     <= '0;
            fpu_x2     <= '0;
            rd_q       <= '0;
            int_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            fpu_funct3 <= req_funct3;
            fpu_funct7 <= req_funct7;
            fpu_x1     <= req_x1;
            fpu_x2     <= req_x2;
            rd_q       <= req_rd;
            int_q      <= dec_int;
            cnt_q      <= dec_lat;
        end else if (state_q == ST_EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_is_int <= 1'b0;
        end else begin
            wb_valid <= capture;
            if (capture) begin
                wb_rd     <= rd_q;
                wb_data   <= fpu_y;
                wb_is_int <= int_q;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized + directed bench for fpu_issue_ctrl against a timestamp model.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [31:0] req_x1, req_x2;
    logic        flush;
    logic [2:0]  fpu_funct3;
    logic [6:0]  fpu_funct7;
    logic [31:0] fpu_x1, fpu_x2, fpu_y;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_is_int;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    fpu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct3(req_funct3),
        .req_funct7(req_funct7),
        .req_rd    (req_rd),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .flush     (flush),
        .fpu_funct3(fpu_funct3),
        .fpu_funct7(fpu_funct7),
        .fpu_x1    (fpu_x1),
        .fpu_x2    (fpu_x2),
        .fpu_y     (fpu_y),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_is_int (wb_is_int),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: known answers for the directed vectors, a hash otherwise.
    function automatic logic [31:0] fake_fpu(input logic [2:0] f3,
                                             input logic [6:0] f7,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        if (f7 == 7'h00 && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        if (f7 == 7'h50 && f3 == 3'd0 && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h00000001;
        if (f7 == 7'h68 && a == 32'd5)
            return 32'h40A00000;
        if (f7 == 7'h08 && a == 32'h40000000 && b == 32'h40400000)
            return 32'h40C00000;
        if (f7 == 7'h04 && a == 32'h3F800000 && b == 32'h3F800000)
            return 32'h00000000;
        return (a ^ {b[15:0], b[31:16]} ^ {22'h0, f7, f3}) + 32'h9E3779B9;
    endfunction

    assign fpu_y = fake_fpu(fpu_funct3, fpu_funct7, fpu_x1, fpu_x2);

    function automatic int lat_of(input logic [6:0] f7);
        if (f7 == 7'h00 || f7 == 7'h04) return 2;
        if (f7 == 7'h68) return 1;
        return 0;
    endfunction

    function automatic bit int_of(input logic [6:0] f7);
        return (f7 == 7'h50) || (f7 == 7'h70);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Model: an accepted op captures at accept_cycle+1+L unless flushed.
    int          n;
    int          cap_cycle;
    bit          inflight;
    bit          pulse_now;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_x1, m_x2;
    logic [4:0]  op_rd;
    bit          op_int;
    logic [31:0] op_data;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    bit          m_wb_int;

    task automatic model_reset();
        n = 0; cap_cycle = 0; inflight = 0; pulse_now = 0;
        m_f3 = '0; m_f7 = '0; m_x1 = '0; m_x2 = '0;
        op_rd = '0; op_int = 0; op_data = '0;
        m_wb_rd = '0; m_wb_data = '0; m_wb_int = 0;
    endtask

    task automatic cycle(input bit v, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit fl);
        bit rdy;
        bit nxt;
        @(posedge clk);
        #1;
        check("wb_valid", {31'b0, wb_valid}, {31'b0, pulse_now});
        check("wb_rd", {27'b0, wb_rd}, {27'b0, m_wb_rd});
        check("wb_data", wb_data, m_wb_data);
        check("wb_is_int", {31'b0, wb_is_int}, {31'b0, m_wb_int});
        check("busy", {31'b0, busy}, {31'b0, inflight | pulse_now});
        check("fpu_funct3", {29'b0, fpu_funct3}, {29'b0, m_f3});
        check("fpu_funct7", {25'b0, fpu_funct7}, {25'b0, m_f7});
        check("fpu_x1", fpu_x1, m_x1);
        check("fpu_x2", fpu_x2, m_x2);
        req_valid = v; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_x1 = a; req_x2 = b; flush = fl;
        #1;
        rdy = !inflight && !fl;
        check("req_ready", {31'b0, req_ready}, {31'b0, rdy});
        nxt = inflight && (n == cap_cycle) && !fl;
        if (nxt) begin
            m_wb_rd = op_rd; m_wb_data = op_data; m_wb_int = op_int;
            inflight = 0;
        end else if (inflight && fl) begin
            inflight = 0;
        end
        if (v && rdy) begin
            m_f3 = f3; m_f7 = f7; m_x1 = a; m_x2 = b;
            op_rd = rd; op_int = int_of(f7);
            op_data = fake_fpu(f3, f7, a, b);
            cap_cycle = n + 1 + lat_of(f7);
            inflight = 1;
        end
        pulse_now = nxt;
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0, 0);
    endtask

    logic [6:0] pool [8] = '{7'h00, 7'h04, 7'h08, 7'h10,
                             7'h50, 7'h68, 7'h70, 7'h78};

    initial begin
        rst = 1'b1;
        req_valid = 0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_x1 = '0; req_x2 = '0; flush = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        idle(2);

        cycle(1, 3'd0, 7'h00, 5'd3, 32'h3F800000, 32'h40000000, 0);
        idle(5);
        check("fadd_data", wb_data, 32'h40400000);
        check("fadd_int", {31'b0, wb_is_int}, 32'd0);

        cycle(1, 3'd0, 7'h50, 5'd7, 32'h3F800000, 32'h40000000, 0);
        idle(3);
        check("fle_data", wb_data, 32'd1);
        check("fle_rd", {27'b0, wb_rd}, 32'd7);
        check("fle_int", {31'b0, wb_is_int}, 32'd1);

        cycle(1, 3'd0, 7'h68, 5'd2, 32'd5, 32'd0, 0);
        idle(4);
        check("fcvt_data", wb_data, 32'h40A00000);

        cycle(1, 3'd0, 7'h08, 5'd4, 32'h40000000, 32'h40400000, 0);
        cycle(1, 3'd0, 7'h04, 5'd5, 32'h3F800000, 32'h3F800000, 0);
        cycle(1, 3'd0, 7'h04, 5'd5, 32'h3F800000, 32'h3F800000, 0);
        check("b2b_first", wb_data, 32'h40C00000);
        idle(5);
        check("b2b_second", wb_data, 32'h00000000);

        cycle(1, 3'd0, 7'h00, 5'd9, 32'h12345678, 32'h9ABCDEF0, 0);
        idle(1);
        cycle(0, 3'd0, 7'h00, 5'd0, 32'd0, 32'd0, 1);
        idle(10);

        cycle(1, 3'd1, 7'h00, 5'd1, 32'h11111111, 32'h22222222, 1);
        idle(2);

        cycle(1, 3'd0, 7'h00, 5'd6, 32'hCAFEF00D, 32'h0BADBEEF, 0);
        idle(1);
        @(posedge clk);
        #1 req_valid = 0; flush = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fpu_x1", fpu_x1, 32'd0);
        check("rst_fpu_x2", fpu_x2, 32'd0);
        check("rst_fpu_f7", {25'b0, fpu_funct7}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        idle(6);

        for (int i = 0; i < 600; i++) begin
            logic [6:0] f7;
            if ($urandom_range(0, 9) < 8) f7 = pool[$urandom_range(0, 7)];
            else                          f7 = 7'($urandom);
            cycle($urandom_range(0, 9) < 6, 3'($urandom), f7, 5'($urandom),
                  $urandom, $urandom, $urandom_range(0, 15) == 0);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
